// File: rtl/e203_exu_oitf_mt.sv
// Multithread-aware outstanding instruction track FIFO for the long pipe.
// Dispatch allocates entries. Write-back retires the oldest entry. Same-thread RAW/WAW hazards are flagged.
module e203_exu_oitf_mt #(
  parameter int OITF_DEPTH  = 2,
  parameter int THREADS_NUM = 2,
  parameter int ITAG_WIDTH  = 1,
  parameter int RFIDX_WIDTH = 5,
  parameter int PC_SIZE     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  // Handshake semantics: dis_ena is a completed transfer and is only legal while dis_ready=1.
  // oitf_ret_ena is a completed pop and is only legal while oitf_empty=0.
  // An illegal request is ignored and leaves all state untouched.
  input  logic                   dis_ena,
  output logic                   dis_ready,
  output logic [ITAG_WIDTH-1:0]  dis_ptr,
  input  logic [THREADS_NUM-1:0] dis_thread_sel,
  input  logic [RFIDX_WIDTH-1:0] dis_rdidx,
  input  logic                   dis_rdwen,
  input  logic                   dis_rdfpu,
  input  logic [PC_SIZE-1:0]     dis_pc,
  input  logic [THREADS_NUM-1:0] disp_thread_sel,
  input  logic                   disp_rs1en,
  input  logic                   disp_rs2en,
  input  logic                   disp_rs3en,
  input  logic                   disp_rdwen,
  input  logic                   disp_rs1fpu,
  input  logic                   disp_rs2fpu,
  input  logic                   disp_rs3fpu,
  input  logic                   disp_rdfpu,
  input  logic [RFIDX_WIDTH-1:0] disp_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rs2idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rs3idx,
  input  logic [RFIDX_WIDTH-1:0] disp_rdidx,
  output logic                   oitfrd_match_disprs1,
  output logic                   oitfrd_match_disprs2,
  output logic                   oitfrd_match_disprs3,
  output logic                   oitfrd_match_disprd,
  output logic                   oitf_empty,
  output logic [ITAG_WIDTH-1:0]  oitf_ret_ptr,
  output logic [RFIDX_WIDTH-1:0] oitf_ret_rdidx,
  output logic [PC_SIZE-1:0]     oitf_ret_pc,
  output logic                   oitf_ret_rdwen,
  output logic                   oitf_ret_rdfpu,
  output logic [THREADS_NUM-1:0] oitf_ret_thread_sel,
  input  logic                   oitf_ret_ena
);

  localparam logic [ITAG_WIDTH-1:0] LAST_IDX = ITAG_WIDTH'(OITF_DEPTH - 1);

  logic [ITAG_WIDTH-1:0]  alloc_ptr, ret_ptr;
  logic                   alloc_flg, ret_flg;
  logic [OITF_DEPTH-1:0]  vld;
  logic [RFIDX_WIDTH-1:0] rdidx_q  [OITF_DEPTH];
  logic                   rdwen_q  [OITF_DEPTH];
  logic                   rdfpu_q  [OITF_DEPTH];
  logic [PC_SIZE-1:0]     pc_q     [OITF_DEPTH];
  logic [THREADS_NUM-1:0] thread_q [OITF_DEPTH];

  logic full, empty, dis_fire, ret_fire;

  assign full      = (alloc_ptr == ret_ptr) && (alloc_flg != ret_flg);
  assign empty     = (alloc_ptr == ret_ptr) && (alloc_flg == ret_flg);
  assign dis_ready = ~full;
  assign dis_fire  = dis_ena & ~full;
  assign ret_fire  = oitf_ret_ena & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr <= '0;
      alloc_flg <= 1'b0;
      ret_ptr   <= '0;
      ret_flg   <= 1'b0;
      vld       <= '0;
      for (int i = 0; i < OITF_DEPTH; i++) begin
        rdidx_q[i]  <= '0;
        rdwen_q[i]  <= 1'b0;
        rdfpu_q[i]  <= 1'b0;
        pc_q[i]     <= '0;
        thread_q[i] <= '0;
      end
    end else begin
      if (ret_fire) begin
        vld[ret_ptr] <= 1'b0;
        ret_ptr      <= (ret_ptr == LAST_IDX) ? '0 : ret_ptr + 1'b1;
        if (ret_ptr == LAST_IDX) ret_flg <= ~ret_flg;
      end
      // Alloc and retire never hit the same slot in one cycle, because full or empty blocks one side.
      if (dis_fire) begin
        vld[alloc_ptr]      <= 1'b1;
        rdidx_q[alloc_ptr]  <= dis_rdidx;
        rdwen_q[alloc_ptr]  <= dis_rdwen;
        rdfpu_q[alloc_ptr]  <= dis_rdfpu;
        pc_q[alloc_ptr]     <= dis_pc;
        thread_q[alloc_ptr] <= dis_thread_sel;
        alloc_ptr           <= (alloc_ptr == LAST_IDX) ? '0 : alloc_ptr + 1'b1;
        if (alloc_ptr == LAST_IDX) alloc_flg <= ~alloc_flg;
      end
    end
  end

  assign dis_ptr             = alloc_ptr;
  assign oitf_empty          = empty;
  assign oitf_ret_ptr        = ret_ptr;
  assign oitf_ret_rdidx      = rdidx_q[ret_ptr];
  assign oitf_ret_pc         = pc_q[ret_ptr];
  assign oitf_ret_rdwen      = rdwen_q[ret_ptr];
  assign oitf_ret_rdfpu      = rdfpu_q[ret_ptr];
  assign oitf_ret_thread_sel = thread_q[ret_ptr];

  // A live entry of the same thread that writes the same register in the same register file.
  function automatic logic any_hit(input logic fpu, input logic [RFIDX_WIDTH-1:0] idx);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld[i] && rdwen_q[i] && (thread_q[i] == disp_thread_sel) &&
          (rdfpu_q[i] == fpu) && (rdidx_q[i] == idx))
        hit = 1'b1;
    end
    return hit;
  endfunction

  assign oitfrd_match_disprs1 = disp_rs1en & any_hit(disp_rs1fpu, disp_rs1idx);
  assign oitfrd_match_disprs2 = disp_rs2en & any_hit(disp_rs2fpu, disp_rs2idx);
  assign oitfrd_match_disprs3 = disp_rs3en & any_hit(disp_rs3fpu, disp_rs3idx);
  assign oitfrd_match_disprd  = disp_rdwen & any_hit(disp_rdfpu, disp_rdidx);

endmodule

// File: doc/e203_exu_oitf_mt.md
Name: e203_exu_oitf_mt

Overview:
Multithread-aware Outstanding Instruction Track FIFO (OITF) for the long-pipe path. The dispatch stage allocates one entry per long-pipe instruction, such as an LSU load or store, and receives the entry's itag. The retire side presents the oldest entry's itag, rd index, PC and write-enable flags to the long-pipe write-back arbiter, which pops the entry with oitf_ret_ena. The block also flags RAW/WAW hazards against in-flight entries of the same thread, so dispatch can stall.

Parameters:
OITF_DEPTH, 2, number of entries; power of two, at least 2.
THREADS_NUM, 2, hardware thread count; thread_sel is one-hot of this width.
ITAG_WIDTH, 1, log2(OITF_DEPTH).
RFIDX_WIDTH, 5, register index width.
PC_SIZE, 32, PC width.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous reset, active-high.
dis_ena  in  1  allocate handshake: valid and accepted; legal only when dis_ready=1.
dis_ready  out  1  1 when the FIFO is not full.
dis_ptr  out  ITAG_WIDTH  itag that the next allocation receives (alloc pointer).
dis_thread_sel  in  THREADS_NUM  owning thread, one-hot.
dis_rdidx  in  RFIDX_WIDTH  destination register.
dis_rdwen  in  1  instruction writes rd.
dis_rdfpu  in  1  rd is in the FP register file.
dis_pc  in  PC_SIZE  instruction PC.
disp_thread_sel  in  THREADS_NUM  thread of the instruction being hazard-checked.
disp_rs1en, disp_rs2en, disp_rs3en, disp_rdwen  in  1 each  operand and destination enables.
disp_rs1fpu, disp_rs2fpu, disp_rs3fpu, disp_rdfpu  in  1 each  register-file select per operand.
disp_rs1idx, disp_rs2idx, disp_rs3idx, disp_rdidx  in  RFIDX_WIDTH each  operand indices.
oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd  out  1 each  hazard flags.
oitf_empty  out  1  no valid entries.
oitf_ret_ptr  out  ITAG_WIDTH  itag of the oldest entry.
oitf_ret_rdidx  out  RFIDX_WIDTH  rd index of the oldest entry.
oitf_ret_pc  out  PC_SIZE  PC of the oldest entry.
oitf_ret_rdwen  out  1  rd write-enable of the oldest entry.
oitf_ret_rdfpu  out  1  FP flag of the oldest entry.
oitf_ret_thread_sel  out  THREADS_NUM  thread of the oldest entry.
oitf_ret_ena  in  1  pop the oldest entry; legal only when oitf_empty=0.

Behaviour:
- State:
  - alloc_ptr and ret_ptr, each ITAG_WIDTH bits plus a wrap flag bit.
  - Per-entry vld bit.
  - Per-entry payload: rdidx, rdwen, rdfpu, pc, thread_sel.
- Reset (rst=1 at a clock edge):
  - Pointers and flags go to 0; all vld go to 0; all payload goes to 0.
  - Resulting outputs: oitf_empty=1, dis_ready=1, dis_ptr=0, oitf_ret_ptr=0.
  - All other oitf_ret_* outputs are 0; all match outputs are 0.
  - Reset overrides any same-cycle dis_ena or oitf_ret_ena; in-flight entries are discarded.
- Full and empty:
  - full = (alloc_ptr == ret_ptr) and the wrap flags differ.
  - empty = (alloc_ptr == ret_ptr) and the wrap flags are equal.
  - dis_ready = ~full, combinational from registered state.
- Allocate (dis_ena=1):
  - Write the payload at alloc_ptr and set vld.
  - Increment alloc_ptr; on wrap from OITF_DEPTH-1 to 0, toggle its flag.
  - dis_ptr is the pre-increment value, so the instruction's itag equals dis_ptr in the allocation cycle.
- Retire (oitf_ret_ena=1):
  - Clear vld at ret_ptr.
  - Increment ret_ptr with the same wrap and flag rule.
- Retire side outputs:
  - oitf_ret_* are combinational reads of the entry at ret_ptr.
  - When empty they show stale payload; consumers must qualify them with oitf_empty.
- Simultaneous allocate and retire:
  - Both occur in the same cycle; the occupancy count is unchanged.
  - When full, dis_ready=0; a retire in that cycle does not bypass to allow an allocate.
  - When empty, the new entry becomes visible on oitf_ret_* on the next cycle, not the same cycle. Zero-latency bypass is not supported.
- Latency: allocate-to-retire-visible is 1 cycle; retire-to-dis_ready-rise is 1 cycle.
- Hazard matching:
  - oitfrd_match_disprsN = OR over entries of: vld & rdwen & (thread_sel == disp_thread_sel) & (rdfpu == disp_rsNfpu) & (rdidx == disp_rsNidx), all ANDed with disp_rsNen.
  - oitfrd_match_disprd uses the same rule with disp_rdwen, disp_rdfpu and disp_rdidx.
  - Matches are purely combinational and look only at registered state; an entry being allocated in the same cycle is not visible until the next cycle.
  - Entries owned by other threads never produce a match.
- Protocol violations (dis_ena while full, oitf_ret_ena while empty): state must be left unchanged, and the bench flags them with assertions.
- No per-thread flush. A pipeline flush drains through normal retire.

Test Plan:
- Reset, then idle → oitf_empty=1, dis_ready=1, dis_ptr=0, every oitf_ret_* and match output is 0.
- With DEPTH=2, allocate rdidx=5 (pc=0x100) then rdidx=7 (pc=0x104) with no retires → dis_ready=0 after the second allocate, oitf_ret_ptr=0, oitf_ret_rdidx=5, oitf_ret_pc=0x100. A dis_ena asserted while full changes no state.
- From full, retire twice → oitf_ret_pc reads 0x104 after the first retire, then oitf_empty=1. The next allocate gets dis_ptr=0 with the alloc wrap flag toggled, and full/empty decode stays correct across 4 wraps.
- Hold one entry, then allocate and retire in the same cycle for 10 cycles → occupancy stays 1, oitf_ret_ptr alternates 0/1, and oitf_empty never rises.
- Entry from thread 0 with rdidx=3, rdwen=1 → disp_rs1idx=3, disp_rs1en=1, thread 0 gives match_disprs1=1. The same check with thread 1, or with disp_rs1fpu=1, or with disp_rs1en=0, gives 0.
- Assert rst while 2 entries are valid, together with dis_ena=1 and oitf_ret_ena=1 → the next cycle shows oitf_empty=1, dis_ptr=0, and all matches 0.
